// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: FSM state encoding, owner encoding and default sizes for the SRAM port arbiter
package sram_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_CYCLES_DEF = 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_MEM = 1'b1;
endpackage

// File: rtl/sram_port_arbiter_if_line_buf.sv
// if_line_buf: one-entry fetch buffer (valid bit, tag, data) with tag compare, used under IF_LINE_BUF_EN
module if_line_buf
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] inv_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;
  // refill on every SRAM fetch; a data write to the buffered address drops the entry
  always_ff @(posedge clk)
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q <= '0;
      data_q <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q <= fill_addr_i;
      data_q <= fill_data_i;
    end else if (inv_i && inv_addr_i == tag_q) valid_q <= 1'b0;
  assign hit_o = valid_q && lookup_addr_i == tag_q;
  assign data_o = data_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM between IF and MEM (MEM first); define IF_LINE_BUF_EN for a one-entry fetch buffer
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_conflict,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);
  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              rd_last;
  assign rd_last = state_q == S_RD && cnt_q == '0;
`ifdef IF_LINE_BUF_EN
  if_line_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_line_buf (
    .clk(clk),
    .rst(rst),
    .lookup_addr_i(if_addr),
    .fill_i(rd_last && owner_q == OWN_IF),
    .fill_addr_i(addr_q),
    .fill_data_i(sram_dq_i),
    .inv_i(state_q == S_IDLE && mem_req && mem_we),
    .inv_addr_i(mem_addr),
    .hit_o(buf_hit),
    .data_o(buf_data)
  );
`else
  assign buf_hit = 1'b0;
  assign buf_data = '0;
`endif
  // access sequencer: accept in IDLE (MEM first), time the strobes, capture read data on the last RD cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if_rdata_d = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE:
        if (mem_req) begin
          owner_d = OWN_MEM;
          addr_d = mem_addr;
          cnt_d = CNT_LOAD;
          wdata_d = mem_we ? mem_wdata : wdata_q;
          state_d = mem_we ? S_WR_SETUP : S_RD;
        end else if (if_req) begin
          owner_d = OWN_IF;
          addr_d = if_addr;
          cnt_d = CNT_LOAD;
          if_rdata_d = buf_hit ? buf_data : if_rdata_q;
          state_d = buf_hit ? S_DONE : S_RD;
        end
      S_RD: begin
        cnt_d = cnt_q - CW'(1);
        state_d = rd_last ? S_DONE : S_RD;
        if_rdata_d = rd_last && owner_q == OWN_IF ? sram_dq_i : if_rdata_q;
        mem_rdata_d = rd_last && owner_q == OWN_MEM ? sram_dq_i : mem_rdata_q;
      end
      S_WR_SETUP: begin
        cnt_d = CNT_LOAD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? S_WR_HOLD : S_WR_PULSE;
      end
      S_WR_HOLD: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any access without a done pulse
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  assign sram_addr = addr_q;
  assign sram_dq_o = wdata_q;
  assign sram_ce_n = state_q == S_IDLE || state_q == S_DONE;
  assign sram_oe_n = state_q != S_RD;
  assign sram_we_n = state_q != S_WR_PULSE;
  assign sram_dq_oe = state_q == S_WR_SETUP || state_q == S_WR_PULSE || state_q == S_WR_HOLD;
  assign if_valid = state_q == S_DONE && owner_q == OWN_IF;
  assign mem_done = state_q == S_DONE && owner_q == OWN_MEM;
  assign mem_conflict = if_req && (state_q == S_IDLE ? mem_req : owner_q == OWN_MEM);
  assign if_rdata = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
endmodule
